// File: rtl/plru_pkg.sv
// Shared types and helpers for tree-PLRU logic.
// Contents:
//   state_e      - controller state (idle / multi-beat transfer in flight)
//   MaxWidth     - largest leaf count the helpers handle
//   path_update  - rewrite the tree bits along one leaf's root-to-leaf path
//   is_onehot    - exactly-one-bit-set test
package plru_pkg;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Helpers work on fixed maximum-size vectors so any WIDTH up to MaxWidth can use them;
  // callers zero-extend inputs and truncate the result.
  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxIdxW  = 6;

  // Walk from the root towards `leaf`, pointing every visited node away from it:
  // 0 when the leaf sits in the node's lower half, 1 when in the upper half.
  function automatic logic [MaxWidth-2:0] path_update(input logic [MaxWidth-2:0] tree,
                                                      input logic [MaxIdxW-1:0]  leaf,
                                                      input int unsigned         levels);
    logic [MaxWidth-2:0] t;
    int unsigned         n;
    logic                b;
    t = tree;
    n = 0;
    for (int unsigned l = 0; l < MaxIdxW; l++) begin
      if (l < levels) begin
        b    = leaf[levels-1-l];
        t[n] = b;
        n    = 2 * n + (b ? 32'd2 : 32'd1);
      end
    end
    return t;
  endfunction

  function automatic logic is_onehot(input logic [MaxWidth-1:0] vec);
    return $countones(vec) == 1;
  endfunction

endpackage

// File: rtl/plru_victim_decode.sv
// Combinational tree walk from heap-ordered PLRU bits to the least-recently-used leaf.
// Ports:
//   v_grant       - tree bits, bit 0 = root, children of n at 2n+1 / 2n+2
//   victim_idx    - LRU leaf index
//   victim_onehot - LRU leaf, one-hot
module plru_victim_decode #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-2:0] v_grant,
  output logic [IDXW-1:0]  victim_idx,
  output logic [WIDTH-1:0] victim_onehot
);

  int unsigned node;

  // A set bit sends the walk to the lower child, which contributes a 0 to the index.
  always_comb begin
    victim_idx = '0;
    node       = 0;
    for (int unsigned l = 0; l < IDXW; l++) begin
      victim_idx[IDXW-1-l] = ~v_grant[node];
      node                 = 2 * node + (v_grant[node] ? 32'd1 : 32'd2);
    end
  end

  always_comb begin
    victim_onehot             = '0;
    victim_onehot[victim_idx] = 1'b1;
  end

endmodule

// File: rtl/plru_tree_ctrl.sv
// Owner of the tree-PLRU state for an N-way arbiter / replacement unit.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   clr           - synchronous re-init of all state
//   gnt_vld       - a grant beat is issued this cycle
//   gnt_onehot    - granted requester, one-hot
//   gnt_last      - final beat of the granted transfer
//   v_grant       - registered tree bits (heap order)
//   lock          - multi-beat transfer in progress, arbiter must hold its grant
//   victim_idx    - LRU leaf index (combinational from v_grant)
//   victim_onehot - LRU leaf one-hot
//   err           - one-cycle pulse, registered, after an illegal grant beat
module plru_tree_ctrl
  import plru_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             gnt_vld,
  input  logic [WIDTH-1:0] gnt_onehot,
  input  logic             gnt_last,
  output logic [WIDTH-2:0] v_grant,
  output logic             lock,
  output logic [IDXW-1:0]  victim_idx,
  output logic [WIDTH-1:0] victim_onehot,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-2:0] tree_q, tree_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic             err_q, err_d;

  logic                gnt_legal;
  logic [IDXW-1:0]     gnt_leaf;
  logic [WIDTH-2:0]    tree_upd;
  logic [MaxWidth-1:0] oh_ext;
  logic [MaxWidth-2:0] tree_ext, upd_ext;
  logic [MaxIdxW-1:0]  leaf_ext;

  always_comb begin
    oh_ext               = '0;
    oh_ext[WIDTH-1:0]    = gnt_onehot;
    gnt_legal            = is_onehot(oh_ext);
  end

  // Only meaningful when the grant is one-hot; garbage otherwise is never used.
  always_comb begin
    gnt_leaf = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (gnt_onehot[i]) gnt_leaf = gnt_leaf | IDXW'(i);
    end
  end

  always_comb begin
    tree_ext              = '0;
    tree_ext[WIDTH-2:0]   = tree_q;
    leaf_ext              = '0;
    leaf_ext[IDXW-1:0]    = gnt_leaf;
    upd_ext               = path_update(tree_ext, leaf_ext, IDXW);
    tree_upd              = upd_ext[WIDTH-2:0];
  end

  always_comb begin
    state_d = state_q;
    tree_d  = tree_q;
    held_d  = held_q;
    err_d   = 1'b0;
    if (clr) begin
      state_d = StIdle;
      tree_d  = '1;
      held_d  = '0;
    end else if (gnt_vld) begin
      unique case (state_q)
        StIdle: begin
          if (!gnt_legal) begin
            err_d = 1'b1;
          end else if (gnt_last) begin
            tree_d = tree_upd;
          end else begin
            held_d  = gnt_onehot;
            state_d = StBusy;
          end
        end
        StBusy: begin
          // held_q is always one-hot here, so this also rejects zero/multi-bit beats.
          if (gnt_onehot != held_q) begin
            err_d = 1'b1;
          end else if (gnt_last) begin
            tree_d  = tree_upd;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tree_q  <= '1;
      held_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tree_q  <= tree_d;
      held_q  <= held_d;
      err_q   <= err_d;
    end
  end

  assign v_grant = tree_q;
  assign lock    = (state_q == StBusy);
  assign err     = err_q;

  plru_victim_decode #(
    .WIDTH(WIDTH)
  ) u_victim_decode (
    .v_grant      (tree_q),
    .victim_idx   (victim_idx),
    .victim_onehot(victim_onehot)
  );

endmodule

// File: tb/tb_plru_tree_ctrl.sv
// Scoreboard bench for plru_tree_ctrl (WIDTH=4): a driver issues beats and pushes the
// expected post-edge outputs from a range-based reference model; a monitor pops and compares.
module tb_plru_tree_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, clr, gnt_vld, gnt_last;
  logic [W-1:0] gnt_onehot;
  logic [W-2:0] v_grant;
  logic         lock, err;
  logic [1:0]   victim_idx;
  logic [W-1:0] victim_onehot;

  always #5 clk = ~clk;

  plru_tree_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .gnt_vld      (gnt_vld),
    .gnt_onehot   (gnt_onehot),
    .gnt_last     (gnt_last),
    .v_grant      (v_grant),
    .lock         (lock),
    .victim_idx   (victim_idx),
    .victim_onehot(victim_onehot),
    .err          (err)
  );

  typedef struct packed {
    logic [W-2:0] tree;
    logic         lock;
    logic         err;
    logic [1:0]   vidx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [W-2:0] m_tree;
  bit           m_busy;
  logic [W-1:0] m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Leaf range [lo,hi) covered by heap node n, split at mid.
  function automatic void node_range(input int n, output int lo, output int mid, output int hi);
    int d = 0;
    int span;
    while ((n + 1) >= (1 << (d + 1))) d++;
    span = W >> d;
    lo   = (n - ((1 << d) - 1)) * span;
    mid  = lo + span / 2;
    hi   = lo + span;
  endfunction

  function automatic logic [W-2:0] model_update(input logic [W-2:0] t, input int leaf);
    int lo, mid, hi;
    logic [W-2:0] r = t;
    for (int n = 0; n < W - 1; n++) begin
      node_range(n, lo, mid, hi);
      if (leaf >= lo && leaf < hi) r[n] = (leaf >= mid);
    end
    return r;
  endfunction

  // The victim is the unique leaf that every covering node points towards.
  function automatic int model_victim(input logic [W-2:0] t);
    int lo, mid, hi;
    bit ok;
    for (int l = 0; l < W; l++) begin
      ok = 1;
      for (int n = 0; n < W - 1; n++) begin
        node_range(n, lo, mid, hi);
        if (l >= lo && l < hi && t[n] != (l < mid)) ok = 0;
      end
      if (ok) return l;
    end
    return -1;
  endfunction

  function automatic int leaf_of(input logic [W-1:0] oh);
    for (int i = 0; i < W; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_tree = '1;
    m_busy = 0;
    m_held = '0;
  endtask

  task automatic step(input logic vld, input logic [W-1:0] oh, input logic last, input logic c);
    exp_t e;
    bit   e_err = 0;
    @(negedge clk);
    gnt_vld    = vld;
    gnt_onehot = oh;
    gnt_last   = last;
    clr        = c;
    if (c) begin
      model_reset();
    end else if (vld) begin
      if (!m_busy) begin
        if ($countones(oh) != 1) e_err = 1;
        else if (last) m_tree = model_update(m_tree, leaf_of(oh));
        else begin
          m_busy = 1;
          m_held = oh;
        end
      end else begin
        if (oh != m_held) e_err = 1;
        else if (last) begin
          m_tree = model_update(m_tree, leaf_of(oh));
          m_busy = 0;
        end
      end
    end
    e.tree = m_tree;
    e.lock = m_busy;
    e.err  = e_err;
    e.vidx = 2'(model_victim(m_tree));
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin : mon
      exp_t e;
      logic [W-1:0] oh;
      e  = exp_q.pop_front();
      oh = '0;
      oh[e.vidx] = 1'b1;
      check("v_grant", 32'(v_grant), 32'(e.tree));
      check("lock", 32'(lock), 32'(e.lock));
      check("err", 32'(err), 32'(e.err));
      check("victim_idx", 32'(victim_idx), 32'(e.vidx));
      check("victim_onehot", 32'(victim_onehot), 32'(oh));
    end
  end

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    gnt_vld    = 1'b0;
    gnt_onehot = '0;
    gnt_last   = 1'b0;
    model_reset();
    #12;
    check("rst_v_grant", 32'(v_grant), 32'h7);
    check("rst_victim_idx", 32'(victim_idx), 32'h0);
    check("rst_victim_onehot", 32'(victim_onehot), 32'h1);
    check("rst_lock", 32'(lock), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat grants
    step(1, 4'b0001, 1, 0);
    settle();
    check("plan_leaf0_tree", 32'(v_grant), 32'h4);
    check("plan_leaf0_victim", 32'(victim_idx), 32'h2);
    step(1, 4'b0100, 1, 0);
    settle();
    check("plan_leaf2_tree", 32'(v_grant), 32'h1);
    check("plan_leaf2_victim", 32'(victim_idx), 32'h1);

    // Multi-beat grant of leaf 3 from reset value
    step(0, 4'b0000, 0, 1);
    step(1, 4'b1000, 0, 0);
    settle();
    check("plan_busy_lock", 32'(lock), 32'h1);
    check("plan_busy_tree", 32'(v_grant), 32'h7);
    step(1, 4'b1000, 0, 0);
    step(0, 4'b0000, 0, 0);
    step(1, 4'b1000, 0, 0);
    step(1, 4'b0001, 1, 0);  // wrong leaf while busy
    step(1, 4'b1000, 1, 0);
    settle();
    check("plan_busy_done_lock", 32'(lock), 32'h0);
    check("plan_busy_done_tree", 32'(v_grant), 32'h7);

    // Illegal grants in idle
    step(1, 4'b0110, 1, 0);
    step(0, 4'b0000, 0, 0);
    step(1, 4'b0000, 1, 0);
    step(0, 4'b0000, 0, 0);

    // clr beats a simultaneous legal grant
    step(1, 4'b0010, 1, 0);
    step(1, 4'b0100, 1, 1);
    step(1, 4'b0010, 0, 0);
    step(1, 4'b0010, 0, 1);
    settle();

    // Asynchronous reset while busy
    step(1, 4'b0100, 0, 0);
    settle();
    gnt_vld = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("arst_lock", 32'(lock), 32'h0);
    check("arst_v_grant", 32'(v_grant), 32'h7);
    check("arst_victim_onehot", 32'(victim_onehot), 32'h1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'b0010, 1, 0);
    settle();
    check("plan_leaf1_tree", 32'(v_grant), 32'h6);
    check("plan_leaf1_victim", 32'(victim_idx), 32'h2);

    // Randomized traffic biased towards legal behaviour
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] oh;
      int           r;
      r  = int'($urandom_range(0, 99));
      oh = W'(1) << $urandom_range(0, W - 1);
      if (m_busy && r < 70) oh = m_held;
      if (r >= 90) oh = W'($urandom_range(0, (1 << W) - 1));
      step(logic'($urandom_range(0, 3) != 0), oh, logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 29) == 0));
    end
    step(0, 4'b0000, 0, 0);

    repeat (4) @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
